// File: rtl/ts_sync_lock.sv
// ts_sync_lock
//   MPEG-2 TS sync acquisition with lock/unlock hysteresis. Hunts for
//   SYNC_BYTE, confirms LOCK_CNT consecutive syncs spaced PKT_LEN bytes
//   apart, then forwards bytes with sop/eop framing and flags bad syncs.
//   Lock is dropped after UNLOCK_CNT consecutive missed syncs.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   byte_in        TS byte, qualified by byte_valid
//   byte_out       byte_in delayed by one cycle
//   out_valid      byte_out belongs to a locked packet
//   out_sop        byte_out is packet byte 0 (with out_valid)
//   out_eop        byte_out is packet byte PKT_LEN-1 (with out_valid)
//   out_sync_err   with out_sop: this packet's sync byte was wrong
//   locked         state is LOCK
//   sync_lost      one-cycle pulse on LOCK -> HUNT
//   pkt_cnt        number of forwarded packets (wraps)
module ts_sync_lock #(
    parameter int unsigned PKT_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic [7:0]       byte_out,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_sync_err,
    output logic             locked,
    output logic             sync_lost,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int unsigned POS_W  = $clog2(PKT_LEN);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(PKT_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } state_t;

    state_t             state, state_n;
    logic [POS_W-1:0]   pos, pos_n, pos_inc;
    logic [GOOD_W-1:0]  good, good_n, good_inc;
    logic [MISS_W-1:0]  miss, miss_n, miss_inc;
    logic               is_sync;
    logic               fwd_n, sop_n, eop_n, err_n, lost_n;

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        good_n   = good;
        miss_n   = miss;
        fwd_n    = 1'b0;
        sop_n    = 1'b0;
        eop_n    = 1'b0;
        err_n    = 1'b0;
        lost_n   = 1'b0;
        is_sync  = (byte_in == SYNC_BYTE);
        pos_inc  = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
        good_inc = good + GOOD_W'(1);
        miss_inc = miss + MISS_W'(1);

        if (byte_valid) begin
            pos_n = pos_inc;
            case (state)
                HUNT: begin
                    pos_n = '0;
                    if (is_sync) begin
                        state_n = VERIFY;
                        pos_n   = POS_W'(1);
                        good_n  = GOOD_W'(1);
                    end
                end
                VERIFY: begin
                    if (pos == '0) begin
                        if (is_sync) begin
                            good_n = good_inc;
                            if (good_inc == GOOD_LOCK) begin
                                // The confirming sync opens the first locked packet.
                                state_n = LOCK;
                                good_n  = '0;
                                fwd_n   = 1'b1;
                                sop_n   = 1'b1;
                            end
                        end else begin
                            // The failing byte is deliberately not re-examined as a new candidate.
                            state_n = HUNT;
                            good_n  = '0;
                            pos_n   = '0;
                        end
                    end
                end
                LOCK: begin
                    fwd_n = 1'b1;
                    eop_n = (pos == LAST_POS);
                    if (pos == '0) begin
                        sop_n = 1'b1;
                        if (is_sync) begin
                            miss_n = '0;
                        end else if (miss_inc == MISS_DROP) begin
                            // Lock drops on this byte; it is not forwarded.
                            state_n = HUNT;
                            lost_n  = 1'b1;
                            fwd_n   = 1'b0;
                            sop_n   = 1'b0;
                            miss_n  = '0;
                            pos_n   = '0;
                        end else begin
                            err_n  = 1'b1;
                            miss_n = miss_inc;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    pos_n   = '0;
                    good_n  = '0;
                    miss_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            pos          <= '0;
            good         <= '0;
            miss         <= '0;
            byte_out     <= '0;
            out_valid    <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_sync_err <= 1'b0;
            locked       <= 1'b0;
            sync_lost    <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            state        <= state_n;
            pos          <= pos_n;
            good         <= good_n;
            miss         <= miss_n;
            byte_out     <= byte_in;
            out_valid    <= fwd_n;
            out_sop      <= sop_n;
            out_eop      <= eop_n;
            out_sync_err <= err_n;
            locked       <= (state_n == LOCK);
            sync_lost    <= lost_n;
            if (sop_n) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

endmodule
